// File: rtl/mul_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mul_uart_tx
// Function : UART 8N1 transmitter sending a captured 16-bit product as two
//            back-to-back frames, low byte first.
// Revision : 1.0
// ============================================================================
module mul_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] prod_low,
    input  logic [7:0] prod_high,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud;
    logic [2:0]       bit_idx;
    logic             byte_idx;
    logic [15:0]      shreg;
    logic             baud_end;

    assign baud_end = (baud == BAUD_LAST);

    // The shift register moves right once per data bit, so after the low
    // frame the high byte already sits in shreg[7:0] for the second frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    baud <= '0;
                    if (start) begin
                        shreg    <= {prod_high, prod_low};
                        byte_idx <= 1'b0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shreg[0];
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shreg <= {1'b0, shreg[15:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_uart_tx
// Function : Scoreboard bench for mul_uart_tx at CLKS_PER_BIT = 4 and 2.
// Revision : 1.0
// ============================================================================
module tb_mul_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] prod_low = 8'h00;
    logic [7:0] prod_high = 8'h00;
    logic       tx4, busy4, done4;
    logic       tx2, busy2, done2;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    mul_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prod_low(prod_low), .prod_high(prod_high),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    mul_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prod_low(prod_low), .prod_high(prod_high),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic launch(input logic [15:0] prod);
        @(negedge clk);
        prod_low  = prod[7:0];
        prod_high = prod[15:8];
        start     = 1'b1;
        exp_q.push_back(prod);
    endtask

    // Records n transfers starting with the first start-bit cycle and decodes
    // the line purely from the 8N1 frame layout.
    task automatic grab(input int cpb, input int n, input bit hold,
                        input int chg_at, input logic [15:0] new_prod, input bit pulse,
                        output logic [15:0] w0, output logic [15:0] w1,
                        output int busy_cyc, output int done_cnt, output int done_first,
                        output int shape_err, output logic next_tx);
        logic s[0:255];
        int   per, total, base;
        logic [15:0] w;
        per = 20 * cpb + 1;
        total = n * per + 1;
        busy_cyc = 0; done_cnt = 0; done_first = -1; shape_err = 0;
        w0 = '0; w1 = '0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (!hold && i == 0) start = 1'b0;
            if (i == chg_at) begin
                prod_low  = new_prod[7:0];
                prod_high = new_prod[15:8];
                if (pulse) start = 1'b1;
            end else if (pulse && i == chg_at + 1) begin
                start = 1'b0;
            end
            s[i] = (cpb == 2) ? tx2 : tx4;
            if (((cpb == 2) ? busy2 : busy4) && i < n * per) busy_cyc++;
            if ((cpb == 2) ? done2 : done4) begin
                done_cnt++;
                if (done_first < 0) done_first = i;
            end
        end
        for (int t = 0; t < n; t++) begin
            base = t * per;
            w = '0;
            for (int k = 0; k < 20; k++)
                for (int j = 1; j < cpb; j++)
                    if (s[base + k*cpb + j] !== s[base + k*cpb]) shape_err++;
            if (s[base] !== 1'b0)            shape_err++;
            if (s[base + 9*cpb] !== 1'b1)    shape_err++;
            if (s[base + 10*cpb] !== 1'b0)   shape_err++;
            if (s[base + 19*cpb] !== 1'b1)   shape_err++;
            if (s[base + 20*cpb] !== 1'b1)   shape_err++;
            for (int b = 0; b < 8; b++) begin
                w[b]     = s[base + (1 + b)*cpb];
                w[8 + b] = s[base + (11 + b)*cpb];
            end
            if (t == 0) w0 = w; else w1 = w;
        end
        next_tx = s[n * per];
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx4, busy4, done4, tx2, busy2, done2} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_state: got %b required 100100", {tx4, busy4, done4, tx2, busy2, done2});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic single(input string nm, input logic [15:0] prod, input int cpb);
        logic [15:0] w0, w1, e;
        int bc, dc, df, se;
        logic nt;
        do_reset();
        launch(prod);
        grab(cpb, 1, 1'b0, -1, 16'h0, 1'b0, w0, w1, bc, dc, df, se, nt);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_queue: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (w0 !== e) begin errors++; $display("FAIL %s_word: got %h required %h", nm, w0, e); end
        end
        checks++;
        if (bc != 20*cpb) begin errors++; $display("FAIL %s_busy: got %0d required %0d", nm, bc, 20*cpb); end
        checks++;
        if (dc != 1 || df != 20*cpb) begin
            errors++; $display("FAIL %s_done: got count %0d at %0d required 1 at %0d", nm, dc, df, 20*cpb);
        end
        checks++;
        if (se != 0) begin errors++; $display("FAIL %s_shape: got %0d framing errors required 0", nm, se); end
    endtask

    task automatic test_single();     single("single", 16'h009C, 4);  endtask
    task automatic test_extremes();   single("extreme", 16'hFE01, 4); endtask
    task automatic test_min_divider(); single("min", 16'h5AA5, 2);    endtask

    task automatic test_ignore_start();
        logic [15:0] w0, w1, e;
        int bc, dc, df, se;
        logic nt;
        do_reset();
        launch(16'h009C);
        grab(4, 1, 1'b0, 30, 16'h1234, 1'b1, w0, w1, bc, dc, df, se, nt);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (w0 !== e) begin errors++; $display("FAIL ignore_word: got %h required %h", w0, e); end
        checks++;
        if (dc != 1 || df != 80 || bc != 80) begin
            errors++; $display("FAIL ignore_timing: got done %0d at %0d busy %0d required 1 at 80 busy 80", dc, df, bc);
        end
        checks++;
        if (se != 0) begin errors++; $display("FAIL ignore_shape: got %0d required 0", se); end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        launch(16'h005A);
        repeat (50) @(negedge clk);
        checks++;
        if (tx4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++; $display("FAIL prereset_line: got tx %b busy %b required 0 1", tx4, busy4);
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx4, busy4, done4} !== 3'b100) begin
            errors++; $display("FAIL async_reset: got %b required 100", {tx4, busy4, done4});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w0, w1, e0, e1;
        int bc, dc, df, se;
        logic nt;
        do_reset();
        launch(16'h1357);
        exp_q.push_back(16'hABCD);
        grab(4, 2, 1'b1, 40, 16'hABCD, 1'b0, w0, w1, bc, dc, df, se, nt);
        start = 1'b0;
        e0 = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        e1 = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (w0 !== e0) begin errors++; $display("FAIL b2b_first: got %h required %h", w0, e0); end
        checks++;
        if (w1 !== e1) begin errors++; $display("FAIL b2b_second: got %h required %h", w1, e1); end
        checks++;
        if (dc != 2 || df != 80) begin errors++; $display("FAIL b2b_done: got %0d first at %0d required 2 first at 80", dc, df); end
        checks++;
        if (bc != 160) begin errors++; $display("FAIL b2b_busy: got %0d required 160", bc); end
        checks++;
        if (nt !== 1'b0) begin errors++; $display("FAIL b2b_restart: got tx %b required 0", nt); end
        checks++;
        if (se != 0) begin errors++; $display("FAIL b2b_shape: got %0d required 0", se); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_min_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_uart_tx.md
Name: mul_uart_tx

Overview:
- UART 8N1 transmitter that serialises the 16-bit multiplier product off-chip.
- Captures `prod_high`/`prod_low` from the 8-bit multiplier on a start strobe.
- Sends two back-to-back frames: low byte first, then high byte.
- Sits between the multiplier output bus and a single `uo_out` pin. It frees the wide parallel product bus for the UART/SPI-fed multiplier top.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit period (10 MHz / 115200 baud). Legal range 2..65535. Counter width is derived as $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request to transmit the current product; sampled on rising clk edge
- prod_low  input  8  product bits [7:0]; captured when start is accepted
- prod_high  input  8  product bits [15:8]; captured when start is accepted
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse when the second stop bit completes

Behaviour:
- Reset: one clock; asynchronous active-low reset on rst_n.
  - rst_n low forces tx=1, busy=0, done=0, state=IDLE, and clears the bit counter, baud counter and byte index. This takes effect immediately, without waiting for clk.
  - Reset mid-frame aborts the frame; no partial resume after release.
- All outputs are registered; no combinational path from inputs to tx.
- States: IDLE, START, DATA, STOP; plus byte_idx (0 = low byte, 1 = high byte).
- IDLE:
  - tx=1, busy=0.
  - When start=1 is sampled, latch {prod_high, prod_low} into a 16-bit shift register, set byte_idx=0, enter START, set busy=1.
  - tx goes low on the clock edge that samples start, so latency from start to the start bit is 1 cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - tx = current byte bit[idx], LSB first; each bit is held CLKS_PER_BIT cycles.
  - After bit 7, enter STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx=0: set byte_idx=1 and enter START directly. No idle gap; the high-byte start bit follows the low-byte stop bit immediately.
  - if byte_idx=1: enter IDLE, busy=0, done=1 for exactly that one cycle.
- Frame timing:
  - Total transfer = 20 bit periods = 20*CLKS_PER_BIT cycles.
  - busy is high for exactly 20*CLKS_PER_BIT cycles.
- start while busy=1 is ignored: no re-capture and no queueing. Operand changes during a transfer do not affect the serial data.
- start=1 in the done cycle: that cycle is IDLE, so start is accepted. The next transfer begins with its start bit on the following cycle. Product inputs are re-captured.
- start held high continuously: a new transfer begins on every done cycle, giving back-to-back transfers with no gap.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Restarts at 0 on every state entry, so no bit is shortened.
- No parity, one stop bit, no flow control.

Test Plan:
- CLKS_PER_BIT=4, prod={0x00,0x9C} (0x0C*0x0D), pulse start 1 cycle -> tx sequence per 4 cycles: 0, 0,0,1,1,1,0,0,1, 1, then 0, 0×8, 1. busy high 80 cycles. done pulses once on cycle 81 after start.
- prod={0xFE,0x01} (0xFF*0xFF) -> low frame data bits 1,0,0,0,0,0,0,0; high frame data bits 0,1,1,1,1,1,1,1. Second start bit begins exactly at cycle 40 after the first start bit.
- Second start pulse at cycle 30 with new prod=0x1234 -> ignored. Serial data is still the first captured product, and done still occurs at cycle 81.
- Assert rst_n=0 during DATA of the high byte -> tx=1, busy=0, done=0 without waiting for clk. After release, tx stays 1 until the next start.
- Hold start=1 through done with prod changed to 0xABCD -> new start bit on the cycle after done, transmitting 0xCD then 0xAB. done pulses once per transfer.
- CLKS_PER_BIT=2 (minimum) -> every bit held exactly 2 cycles. Total busy time 40 cycles, no glitches on tx.
